// File: rtl/spi_reg_responder_if.sv
// ---------------------------------------------------------------------------
// spi_reg_responder_if
//
// Purpose:
//   Bundles the five board-level SPI pins of the register responder so the
//   responder and whatever drives it (MCU model, test bench) share one
//   connection object.
//
// Signals:
//   SPI_SCLK     SPI clock from the external master, idle low (mode 0)
//   SPI_CS       chip select, active-low
//   SPI_MOSI     master-out / slave-in data
//   SPI_MISO     slave-out / master-in data
//   SPI_MISO_OE  high while the responder owns MISO; the board tri-states
//                MISO whenever this is low
//
// Modports:
//   master  drives SCLK/CS/MOSI, observes MISO/MISO_OE
//   slave   observes SCLK/CS/MOSI, drives MISO/MISO_OE
// ---------------------------------------------------------------------------
interface spi_reg_responder_if;

    logic SPI_SCLK;
    logic SPI_CS;
    logic SPI_MOSI;
    logic SPI_MISO;
    logic SPI_MISO_OE;

    modport master (
        output SPI_SCLK,
        output SPI_CS,
        output SPI_MOSI,
        input  SPI_MISO,
        input  SPI_MISO_OE
    );

    modport slave (
        input  SPI_SCLK,
        input  SPI_CS,
        input  SPI_MOSI,
        output SPI_MISO,
        output SPI_MISO_OE
    );

endinterface

// File: rtl/spi_reg_responder.sv
// ---------------------------------------------------------------------------
// spi_reg_responder
//
// Purpose:
//   SPI mode-0 slave that lets an external master read board state and write
//   a control byte using 16-bit frames (command byte, then data byte, MSB
//   first). Command byte: bit7 = 1 for read, bits3:0 = address.
//
//   Register map
//     0 : DEV_ID                  (RO)
//     1 : {4'h0, Status_In}       (RO)
//     2 : {4'h0, snap[11:8]}      (RO)
//     3 : snap[7:0]               (RO)
//     4 : Ctrl_Out                (RW)
//     5 : scratch                 (RW)
//     6..15 : read 8'h00, writes ignored
//
// Ports:
//   Sys_CLK    system clock (50 MHz)
//   Sys_RST    asynchronous reset, active-low
//   spi        SPI pins (slave modport of spi_reg_responder_if)
//   Data_In    12-bit value readable at addresses 2/3, snapshotted per frame
//   Status_In  4-bit value readable at address 1
//   Ctrl_Out   control register (address 4)
//   Wr_Strobe  1-cycle pulse when a write to address 4 or 5 commits
//   Rd_Strobe  1-cycle pulse when read data is loaded for shifting
//   Frame_Err  1-cycle pulse when CS rises before 16 bits were clocked
//
// Parameters:
//   DEV_ID       constant returned at address 0
//   SYNC_STAGES  synchronizer depth on SCLK/CS/MOSI (must be >= 2)
// ---------------------------------------------------------------------------
module spi_reg_responder #(
    parameter logic [7:0] DEV_ID      = 8'hA5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                Sys_CLK,
    input  logic                Sys_RST,
    spi_reg_responder_if.slave  spi,
    input  logic [11:0]         Data_In,
    input  logic [3:0]          Status_In,
    output logic [7:0]          Ctrl_Out,
    output logic                Wr_Strobe,
    output logic                Rd_Strobe,
    output logic                Frame_Err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_END
    } state_t;

    state_t state;
    state_t state_next;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES:0]   valid_sr;
    logic                   sclk_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sclk_d;
    logic                   cs_d;
    logic                   armed;

    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   cs_fall;
    logic                   cs_rise;

    logic [4:0]             bit_cnt;
    logic [7:0]             cmd_reg;
    logic [7:0]             data_reg;
    logic [6:0]             tx_reg;
    logic                   miso_reg;
    logic [11:0]            snap;
    logic [7:0]             ctrl_reg;
    logic [7:0]             scratch_reg;
    logic                   wr_strobe_reg;
    logic                   rd_strobe_reg;
    logic                   frame_err_reg;

    logic [7:0]             cmd_full;
    logic [7:0]             rd_byte;

    logic                   do_capture;
    logic                   do_shift_in;
    logic                   do_load_tx;
    logic                   do_shift_tx;
    logic                   do_commit;
    logic                   do_frame_err;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Edge detection compares the synchronized level with its one-cycle
    // delayed copy. A CS falling edge is only honoured once 'armed', i.e.
    // after CS has been observed high with real pin samples since reset, so
    // a reset released in the middle of a frame never decodes a partial one.
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = armed & ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    // The command byte including the bit arriving on the current rising
    // edge, so the 8th edge can already decode the read address.
    assign cmd_full = {cmd_reg[6:0], mosi_s};

    assign Ctrl_Out            = ctrl_reg;
    assign Wr_Strobe           = wr_strobe_reg;
    assign Rd_Strobe           = rd_strobe_reg;
    assign Frame_Err           = frame_err_reg;
    assign spi.SPI_MISO_OE     = ~cs_s;
    assign spi.SPI_MISO        = miso_reg & ~cs_s;

    // Synchronizers and edge-detect history. valid_sr fills with ones after
    // reset; once full, the synchronizer outputs reflect actual pin levels
    // instead of their reset values, and only then may CS-high arm the FSM.
    always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
        if (!Sys_RST) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
            valid_sr  <= '0;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.SPI_SCLK};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.SPI_CS};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.SPI_MOSI};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
            valid_sr  <= {valid_sr[SYNC_STAGES-1:0], 1'b1};
            if (valid_sr[SYNC_STAGES] && cs_s) begin
                armed <= 1'b1;
            end
        end
    end

    // Read multiplexer, addressed by the freshly completed command byte.
    always_comb begin
        rd_byte = 8'h00;
        case (cmd_full[3:0])
            4'd0:    rd_byte = DEV_ID;
            4'd1:    rd_byte = {4'h0, Status_In};
            4'd2:    rd_byte = {4'h0, snap[11:8]};
            4'd3:    rd_byte = snap[7:0];
            4'd4:    rd_byte = ctrl_reg;
            4'd5:    rd_byte = scratch_reg;
            default: rd_byte = 8'h00;
        endcase
    end

    // FSM state register.
    always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
        if (!Sys_RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath enables. A CS rise always wins over SCLK
    // edges. In DATA the falling edge right after the command byte must not
    // shift: MISO already shows tx bit 7 from the load, and the master only
    // samples it on the following rising edge. Falls after rising edges
    // 9..15 give the remaining seven shifts.
    always_comb begin
        state_next   = state;
        do_capture   = 1'b0;
        do_shift_in  = 1'b0;
        do_load_tx   = 1'b0;
        do_shift_tx  = 1'b0;
        do_commit    = 1'b0;
        do_frame_err = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_next = ST_CMD;
                    do_capture = 1'b1;
                end
            end
            ST_CMD: begin
                if (cs_rise) begin
                    state_next   = ST_IDLE;
                    do_frame_err = 1'b1;
                end else if (sclk_rise) begin
                    do_shift_in = 1'b1;
                    if (bit_cnt == 5'd7) begin
                        state_next = ST_DATA;
                        do_load_tx = cmd_full[7];
                    end
                end
            end
            ST_DATA: begin
                if (cs_rise) begin
                    state_next   = ST_IDLE;
                    do_frame_err = 1'b1;
                end else if (sclk_rise) begin
                    do_shift_in = 1'b1;
                    if (bit_cnt == 5'd15) begin
                        state_next = ST_END;
                    end
                end else if (sclk_fall && cmd_reg[7] && (bit_cnt >= 5'd9)) begin
                    do_shift_tx = 1'b1;
                end
            end
            ST_END: begin
                if (cs_rise) begin
                    state_next = ST_IDLE;
                    do_commit  = ~cmd_reg[7] &&
                                 ((cmd_reg[3:0] == 4'd4) || (cmd_reg[3:0] == 4'd5));
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: shift registers, bit counter, snapshot, writable registers
    // and the registered strobes. The counter stops at 16 because END never
    // asserts do_shift_in.
    always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
        if (!Sys_RST) begin
            bit_cnt       <= '0;
            cmd_reg       <= '0;
            data_reg      <= '0;
            tx_reg        <= '0;
            miso_reg      <= 1'b0;
            snap          <= '0;
            ctrl_reg      <= '0;
            scratch_reg   <= '0;
            wr_strobe_reg <= 1'b0;
            rd_strobe_reg <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            wr_strobe_reg <= do_commit;
            rd_strobe_reg <= do_load_tx;
            frame_err_reg <= do_frame_err;

            if (do_capture) begin
                bit_cnt  <= '0;
                cmd_reg  <= '0;
                data_reg <= '0;
                snap     <= Data_In;
            end

            if (do_shift_in) begin
                bit_cnt <= bit_cnt + 5'd1;
                if (state == ST_CMD) begin
                    cmd_reg <= cmd_full;
                end else begin
                    data_reg <= {data_reg[6:0], mosi_s};
                end
            end

            if (do_load_tx) begin
                tx_reg   <= rd_byte[6:0];
                miso_reg <= rd_byte[7];
            end else if (do_shift_tx) begin
                tx_reg   <= {tx_reg[5:0], 1'b0};
                miso_reg <= tx_reg[6];
            end else if ((state_next == ST_IDLE) || (state_next == ST_END)) begin
                miso_reg <= 1'b0;
            end

            if (do_commit) begin
                if (cmd_reg[3:0] == 4'd4) begin
                    ctrl_reg <= data_reg;
                end else begin
                    scratch_reg <= data_reg;
                end
            end
        end
    end

endmodule

// File: doc/spi_reg_responder.md
Name: spi_reg_responder

Overview:
SPI slave (mode 0) register responder so an external master/MCU can read board state and write a control byte. It is the responder-side counterpart of the ADC SPI initiator. It sits at top level beside the ADC, UART and display blocks. It exposes the 12-bit ADC/BCD result, a 4-bit status word and a writable control register over a 16-bit framed protocol.

Parameters:
DEV_ID, 8'hA5, constant returned at address 0
SYNC_STAGES, 2, synchronizer flops on SPI_SCLK/SPI_CS/SPI_MOSI (min 2)

Ports:
Sys_CLK  in  1  system clock, 50 MHz
Sys_RST  in  1  reset, asynchronous, active-low
SPI_SCLK  in  1  SPI clock from external master, idle low; half-period >= 4 Sys_CLK cycles
SPI_CS  in  1  chip select, active-low
SPI_MOSI  in  1  master-out data
SPI_MISO  out  1  slave-out data
SPI_MISO_OE  out  1  1 while SPI_CS (synchronized) low; board tri-states MISO otherwise
Data_In  in  12  value readable at addresses 2/3 (e.g. ADC BCD result)
Status_In  in  4  value readable at address 1
Ctrl_Out  out  8  control register (address 4)
Wr_Strobe  out  1  1-cycle pulse when a write to a writable address commits
Rd_Strobe  out  1  1-cycle pulse when read data is loaded for shifting
Frame_Err  out  1  1-cycle pulse on a short frame

Behaviour:
- Reset (Sys_RST=0, async): state IDLE, SPI_MISO=0, SPI_MISO_OE=0, Ctrl_Out=8'h00, scratch=8'h00, all strobes 0, bit counter 0, synchronizer flops cleared (SCLK=0, CS=1).
- Inputs pass through SYNC_STAGES flops plus one edge-detect register. Detected edges lag the pin edge by SYNC_STAGES+1 Sys_CLK cycles.
- Frame: 16 bits, MSB first. Byte 0 = command: bit7 R/W (1=read), bits6:4 ignored, bits3:0 address. Byte 1 = write data (write) or don't-care (read).
- MOSI is sampled on each detected SCLK rising edge. MISO is updated on each detected SCLK falling edge, except at the load point below.
- Register map:
  - 0: DEV_ID (RO)
  - 1: {4'h0, Status_In} (RO)
  - 2: {4'h0, snap[11:8]} (RO)
  - 3: snap[7:0] (RO)
  - 4: Ctrl_Out (RW)
  - 5: scratch (RW)
  - 6..15: read 8'h00, writes ignored.
- snap = Data_In captured on the cycle the CS falling edge is detected. It is held for the whole frame, so addresses 2 and 3 are coherent within a frame.
- FSM:
  - IDLE: MISO=0. Synchronized CS falling edge -> CMD; clear counter; capture snap.
  - CMD: shift in 8 bits. On the 8th rising edge:
    - read command: load tx register with the addressed byte, drive SPI_MISO=tx[7] on the next Sys_CLK, pulse Rd_Strobe, go to DATA.
    - write command: go to DATA; MISO stays 0.
  - DATA: read -> shift tx left on each falling edge (MISO=tx[7]), 7 shifts. Write -> shift in 8 data bits. The 16th rising edge -> END.
  - END: further SCLK edges ignored, MISO=0. CS rising edge -> if write and address is 4 or 5, update the register and pulse Wr_Strobe on the following cycle. Return to IDLE.
  - CS rising edge in CMD or DATA (fewer than 16 bits): pulse Frame_Err, no register update, no Wr_Strobe, -> IDLE.
- Write to a RO or unmapped address: frame completes normally, no update, no Wr_Strobe, no Frame_Err.
- Ctrl_Out/scratch change only on a committed write. Ctrl_Out is stable during and between frames.
- SPI_MISO_OE = inverse of synchronized CS. MISO is 0 whenever OE=0.
- Reset released while SPI_CS is low: stay IDLE until CS is seen high, then wait for a new falling edge. No partial frame is decoded.
- Bit counter is 5 bits; it saturates at 16 in END (no wrap).

Test Plan:
- Read ID: CS low, cmd 8'h80, 8 dummy bits, CS high -> MISO bits 1,0,1,0,0,1,0,1; Rd_Strobe single pulse; Wr_Strobe/Frame_Err stay 0.
- Write/readback: write frame cmd 8'h04 data 8'h3C -> Ctrl_Out=8'h3C and one Wr_Strobe after CS rise. Then read cmd 8'h84 -> MISO returns 8'h3C.
- Snapshot: Data_In=12'h5A7, start read addr 2, change Data_In to 12'hFFF mid-frame -> returns 8'h05. Next frame addr 3 with Data_In=12'h5A7 -> returns 8'hA7.
- Short frame: write cmd 8'h05, CS high after 11 bits -> Frame_Err one pulse; scratch stays 8'h00. Following read of addr 5 returns 8'h00.
- RO/unmapped: write 8'h5A to addr 0 and to addr 9 -> no Wr_Strobe. Read of addr 0 still returns 8'hA5; read of addr 9 returns 8'h00.
- Reset mid-frame: assert Sys_RST low during DATA of a write to addr 4, release with CS low, then clock 5 more bits and raise CS -> Ctrl_Out=8'h00, no strobes. Next full frame decodes correctly.
